pll_sequencer: RTL and testbench

Reset and lock sequencer for the core PLL (50 MHz reference, 56.944444 MHz output). It runs in the reference-clock domain and pulses the PLL reset. It qualifies the PLL `locked` output through a synchroniser and a settle window, retries on timeout, and releases the core's system reset only once the clock is stable. Lock loss or an explicit re-sequence request pulls the core back into reset.

---
 rtl/pll_sequencer.sv | 142 ++++++++++++++
 tb/tb_pll_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_sequencer.sv
// pll_sequencer: PLL reset pulse, lock qualification, retry, and core reset release.
// Latency: pll_locked reaches the FSM after a 2-flop synchroniser; all outputs are registered.
// Backpressure: none. req is honoured only in RUN/FAIL. PLL_RELOCK_EN makes lock loss in RUN re-pulse the PLL.
module pll_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retries
);

  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_SETTLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retries_d;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic             pll_rst_d, sys_rst_n_d, ready_d, fail_d;

  // pll_locked is asynchronous to refclk
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign locked_s = sync_q[1];

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      retries   <= 4'd0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries   <= retries_d;
      pll_rst   <= pll_rst_d;
      sys_rst_n <= sys_rst_n_d;
      ready     <= ready_d;
      fail      <= fail_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retries_d = retries;
    case (state_q)
      S_RESET: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_SETTLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retries == RETRY_MAX) begin
            state_d = S_FAIL;
          end else begin
            retries_d = retries + 4'd1;
            state_d   = S_RESET;
          end
        end
      end
      S_SETTLE: begin
        if (!locked_s) state_d = S_WAIT_LOCK;
        else if (cnt_q == SETTLE_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        // req takes priority over a coincident lock loss
        if (req) begin
          state_d   = S_RESET;
          retries_d = 4'd0;
        end else if (!locked_s) begin
`ifdef PLL_RELOCK_EN
          state_d   = S_RESET;
          retries_d = 4'd0;
`else
          state_d   = S_WAIT_LOCK;
`endif
        end
      end
      S_FAIL: begin
        if (req) begin
          state_d   = S_RESET;
          retries_d = 4'd0;
        end
      end
      default: begin
        state_d   = S_RESET;
        retries_d = 4'd0;
      end
    endcase

    // Shared counter restarts on every state change
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {S_RESET, S_WAIT_LOCK, S_SETTLE}) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    pll_rst_d   = (state_d == S_RESET) || (state_d == S_FAIL);
    sys_rst_n_d = (state_d == S_RUN);
    ready_d     = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
  end

endmodule

// File: tb/tb_pll_sequencer.sv
// Bench for pll_sequencer: elapsed-time reference model checked every cycle, plus literal edge checks.
module tb_pll_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 32;
  localparam int SETTLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;
`ifdef PLL_RELOCK_EN
  localparam logic RELOCK = 1'b1;
`else
  localparam logic RELOCK = 1'b0;
`endif

  logic       refclk;
  logic       rst_n;
  logic       req;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retries;

  int n_vec = 0;
  int n_bad = 0;

  pll_sequencer #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .req       (req),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .fail      (fail),
    .retries   (retries)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  // Reference model: phases end after a number of elapsed edges since entry
  localparam int P_PULSE = 0, P_WAIT = 1, P_SETTLE = 2, P_RUN = 3, P_FAIL = 4;
  int   cyc = 0;
  int   since = 0;
  int   tries = 0;
  int   ph = P_PULSE;
  int   el;
  logic ls1 = 1'b0, ls2 = 1'b0, lk;
  logic seen_rst = 1'b0;

  always @(posedge refclk) begin
    cyc++;
    lk  = ls2;
    ls2 = ls1;
    ls1 = pll_locked;
    if (!rst_n) begin
      ph = P_PULSE; since = cyc; tries = 0;
      ls1 = 1'b0; ls2 = 1'b0;
      seen_rst = 1'b1;
    end else begin
      el = cyc - since;
      case (ph)
        P_PULSE: if (el == RST_CYCLES) begin ph = P_WAIT; since = cyc; end
        P_WAIT: begin
          if (lk) begin
            ph = P_SETTLE; since = cyc;
          end else if (el == LOCK_TIMEOUT) begin
            if (tries == MAX_RETRY) begin
              ph = P_FAIL; since = cyc;
            end else begin
              tries++; ph = P_PULSE; since = cyc;
            end
          end
        end
        P_SETTLE: begin
          if (!lk) begin ph = P_WAIT; since = cyc; end
          else if (el == SETTLE_CYCLES) begin ph = P_RUN; since = cyc; end
        end
        P_RUN: begin
          if (req) begin
            tries = 0; ph = P_PULSE; since = cyc;
          end else if (!lk) begin
            if (RELOCK) begin tries = 0; ph = P_PULSE; end
            else ph = P_WAIT;
            since = cyc;
          end
        end
        default: if (req) begin tries = 0; ph = P_PULSE; since = cyc; end
      endcase
    end
  end

  logic [7:0] exp_v, act_v;
  always @(negedge refclk) begin
    if (seen_rst) begin
      exp_v = {(ph == P_PULSE) || (ph == P_FAIL), ph == P_RUN, ph == P_RUN, ph == P_FAIL, 4'(tries)};
      act_v = {pll_rst, sys_rst_n, ready, fail, retries};
      n_vec++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL model_cycle%0d {pll_rst,sys_rst_n,ready,fail,retries} got %b want %b", cyc, act_v, exp_v);
      end
    end
  end

  task automatic tick();
    @(posedge refclk);
    #2;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // After this returns, the next rising edge is edge 1 after release
  task automatic do_reset();
    rst_n = 1'b0;
    tick_n(3);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; pll_locked = 1'b1;
    #1;

    // Power-up with lock already present
    do_reset();
    tick_n(3);  chk("pwr_pll_rst_e3", 4'(pll_rst), 4'd1);
    tick();     chk("pwr_pll_rst_e4", 4'(pll_rst), 4'd0);
    tick_n(8);  chk("pwr_sys_e12", 4'(sys_rst_n), 4'd0);
    tick();     chk("pwr_sys_e13", 4'(sys_rst_n), 4'd1);
    chk("pwr_ready_e13", 4'(ready), 4'd1);
    chk("pwr_retries", retries, 4'd0);
    tick_n(5);

    // req in RUN: drop on the req edge, full re-sequence
    req = 1'b1; tick(); req = 1'b0;
    chk("req_run_sys", 4'(sys_rst_n), 4'd0);
    chk("req_run_pll_rst", 4'(pll_rst), 4'd1);
    tick_n(12); chk("req_run_sys_e12", 4'(sys_rst_n), 4'd0);
    tick();     chk("req_run_sys_e13", 4'(sys_rst_n), 4'd1);
    tick_n(3);

    // Lock loss in RUN
    pll_locked = 1'b0;
    tick_n(2);  chk("loss_sys_e2", 4'(sys_rst_n), 4'd1);
    tick();     chk("loss_sys_e3", 4'(sys_rst_n), 4'd0);
    chk("loss_pll_rst", 4'(pll_rst), 4'(RELOCK));
    tick_n(3);  chk("loss_pll_rst_p3", 4'(pll_rst), 4'(RELOCK));
    tick();     chk("loss_pll_rst_p4", 4'(pll_rst), 4'd0);
    pll_locked = 1'b1;
    tick_n(10); chk("relock_sys_p14", 4'(sys_rst_n), 4'd0);
    tick();     chk("relock_sys_p15", 4'(sys_rst_n), 4'd1);
    chk("relock_retries", retries, 4'd0);
    tick_n(4);

    // req coincident with lock loss reaching the FSM
    pll_locked = 1'b0;
    tick_n(2);
    req = 1'b1; tick(); req = 1'b0;
    chk("coinc_pll_rst", 4'(pll_rst), 4'd1);
    chk("coinc_sys", 4'(sys_rst_n), 4'd0);
    pll_locked = 1'b1;
    tick_n(13); chk("coinc_sys_e13", 4'(sys_rst_n), 4'd1);
    tick_n(3);

    // req during WAIT_LOCK is ignored
    pll_locked = 1'b0;
    do_reset();
    tick_n(6);
    req = 1'b1; tick(); req = 1'b0;
    chk("req_wait_pll_rst", 4'(pll_rst), 4'd0);
    pll_locked = 1'b1;
    tick_n(10); chk("req_wait_sys_e17", 4'(sys_rst_n), 4'd0);
    tick();     chk("req_wait_sys_e18", 4'(sys_rst_n), 4'd1);
    tick_n(3);

    // One-cycle glitch during SETTLE
    do_reset();
    tick_n(5);
    pll_locked = 1'b0; tick(); pll_locked = 1'b1;
    tick_n(10); chk("glitch_sys_e16", 4'(sys_rst_n), 4'd0);
    tick();     chk("glitch_sys_e17", 4'(sys_rst_n), 4'd1);
    chk("glitch_retries", retries, 4'd0);
    tick_n(3);

    // Reset asserted for one cycle mid-SETTLE
    do_reset();
    tick_n(8);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("midrst_pll_rst", 4'(pll_rst), 4'd1);
    chk("midrst_sys", 4'(sys_rst_n), 4'd0);
    tick_n(12); chk("midrst_sys_e12", 4'(sys_rst_n), 4'd0);
    tick();     chk("midrst_sys_e13", 4'(sys_rst_n), 4'd1);
    tick_n(3);

    // No lock at all: retries exhaust into FAIL, then req recovers
    pll_locked = 1'b0;
    do_reset();
    tick_n(35); chk("fail_retries_e35", retries, 4'd0);
    tick();     chk("fail_retries_e36", retries, 4'd1);
    chk("fail_pll_rst_e36", 4'(pll_rst), 4'd1);
    tick_n(71); chk("fail_flag_e107", 4'(fail), 4'd0);
    chk("fail_pll_rst_e107", 4'(pll_rst), 4'd0);
    tick();     chk("fail_flag_e108", 4'(fail), 4'd1);
    chk("fail_retries_e108", retries, 4'd2);
    chk("fail_pll_rst_e108", 4'(pll_rst), 4'd1);
    tick_n(5);  chk("fail_hold", 4'(fail), 4'd1);
    req = 1'b1; tick(); req = 1'b0;
    chk("fail_req_flag", 4'(fail), 4'd0);
    chk("fail_req_retries", retries, 4'd0);
    chk("fail_req_pll_rst", 4'(pll_rst), 4'd1);
    tick_n(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
